// File: rtl/shift_sequencer.sv
// Round-robin controller sharing one 8-bit serial shift register between two byte requesters.
// Each transaction shifts a tx byte in LSB-first and returns the bits shifted out.
module shift_sequencer #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic [1:0] rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       clear,
  output logic       busy,
  output logic       sh_enable,
  output logic       sh_reset,
  output logic       sh_in,
  input  logic       sh_out
);

  localparam int unsigned     CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   DIV_LAST = CW'(DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx;
  logic [7:0]    rx;
  logic [7:0]    rx_capt;
  logic          last_grant;
  logic          post_reset;
  logic          grant;

  always_comb begin
    grant = (&req_valid) ? ~last_grant : req_valid[1];
  end

  always_comb begin
    rx_capt          = rx;
    rx_capt[bit_cnt] = sh_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      sh_enable  <= 1'b0;
      sh_reset   <= 1'b1;
      sh_in      <= 1'b0;
      post_reset <= 1'b1;
      last_grant <= 1'b1;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx         <= '0;
      rx         <= '0;
    end else begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      sh_enable  <= 1'b0;
      sh_reset   <= post_reset;
      post_reset <= 1'b0;
      case (state)
        // DONE arbitrates like IDLE so the next accept can follow the completion directly.
        IDLE, DONE: begin
          if (clear) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            sh_reset <= 1'b1;
          end else if (|req_valid) begin
            state      <= SHIFT;
            busy       <= 1'b1;
            req_ready  <= grant ? 2'b10 : 2'b01;
            tx         <= grant ? req_data1 : req_data0;
            sh_in      <= grant ? req_data1[0] : req_data0[0];
            last_grant <= grant;
            div_cnt    <= '0;
            bit_cnt    <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
          if (sh_enable) begin
            rx      <= rx_capt;
            bit_cnt <= bit_cnt + 3'd1;
            sh_in   <= tx[bit_cnt + 3'd1];
          end
          if (sh_enable && bit_cnt == 3'd7) begin
            state     <= DONE;
            rsp_valid <= last_grant ? 2'b10 : 2'b01;
            rsp_data  <= rx_capt;
            sh_in     <= 1'b0;
          end else begin
            sh_enable <= (div_cnt == DIV_LAST);
          end
        end
        CLEAR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: DIV=4 and DIV=1 instances, each driving a behavioural 8-bit shift register.
// Expected responses come from a byte-level model: each response is the register's previous contents.
module tb_shift_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid [2];
  logic [7:0] req_data0 [2];
  logic [7:0] req_data1 [2];
  logic [1:0] req_ready [2];
  logic [1:0] rsp_valid [2];
  logic [7:0] rsp_data  [2];
  logic       clear     [2];
  logic       busy      [2];
  logic       sh_enable [2];
  logic       sh_reset  [2];
  logic       sh_in     [2];
  logic       sh_out    [2];
  logic [7:0] sreg      [2];

  logic [7:0] exp_reg  [2];
  logic       exp_last [2];
  int n_cmp  = 0;
  int n_err  = 0;
  int cycles = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_data0(req_data0[0]),
    .req_data1(req_data1[0]), .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
    .rsp_data(rsp_data[0]), .clear(clear[0]), .busy(busy[0]), .sh_enable(sh_enable[0]),
    .sh_reset(sh_reset[0]), .sh_in(sh_in[0]), .sh_out(sh_out[0])
  );

  shift_sequencer #(.DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_data0(req_data0[1]),
    .req_data1(req_data1[1]), .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
    .rsp_data(rsp_data[1]), .clear(clear[1]), .busy(busy[1]), .sh_enable(sh_enable[1]),
    .sh_reset(sh_reset[1]), .sh_in(sh_in[1]), .sh_out(sh_out[1])
  );

  // The shift registers the controllers sequence: MSB in, LSB out, re-init to 0x9F.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (sh_reset[u]) sreg[u] <= 8'h9F;
      else if (sh_enable[u]) sreg[u] <= {sh_in[u], sreg[u][7:1]};
    end
  end
  assign sh_out[0] = sreg[0][0];
  assign sh_out[1] = sreg[1][0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycles++;
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      assert (!(sh_enable[u] && sh_reset[u])) else begin
        n_err++;
        $error("FAIL en_rst_excl: unit %0d observed enable=%0b reset=%0b expected not both",
               u, sh_enable[u], sh_reset[u]);
      end
    end
    if (cycles > 20000) begin
      $display("FAIL timeout: observed %0d cycles expected under 20000", cycles);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      exp_reg[u]  = 8'h9F;
      exp_last[u] = 1'b1;
    end
  endtask

  task automatic chk_reset_vals(input int u);
    chk("rst_req_ready", req_ready[u], 0);
    chk("rst_rsp_valid", rsp_valid[u], 0);
    chk("rst_rsp_data", rsp_data[u], 0);
    chk("rst_busy", busy[u], 0);
    chk("rst_sh_enable", sh_enable[u], 0);
    chk("rst_sh_in", sh_in[u], 0);
    chk("rst_sh_reset", sh_reset[u], 1);
  endtask

  // One transaction: waits for the accept, checks grant, bit pacing, sh_in bits and the response.
  task automatic run_txn(input int u, input bit hold, output int waited);
    int         div;
    int         g;
    int         stray;
    logic [7:0] d;
    logic [1:0] oh;
    div = (u == 0) ? 4 : 1;
    if (req_valid[u] == 2'b11) g = exp_last[u] ? 0 : 1;
    else g = req_valid[u][1] ? 1 : 0;
    d  = (g == 0) ? req_data0[u] : req_data1[u];
    oh = (g == 0) ? 2'b01 : 2'b10;
    waited = 0;
    do begin
      step();
      waited++;
    end while (req_ready[u] == 2'b00 && waited < 60);
    chk("req_ready", req_ready[u], oh);
    chk("busy_accept", busy[u], 1);
    exp_last[u] = g[0];
    if (hold) begin
      if (g == 0) req_data0[u] = 8'($urandom);
      else req_data1[u] = 8'($urandom);
    end else begin
      req_valid[u][g] = 1'b0;
    end
    stray = 0;
    for (int c = 1; c <= 8 * div + 1; c++) begin
      step();
      if (c % div == 0 && c <= 8 * div) begin
        chk("sh_enable", sh_enable[u], 1);
        chk("sh_in", sh_in[u], d[c / div - 1]);
      end else if (sh_enable[u]) begin
        stray++;
      end
      if (c <= 8 * div && rsp_valid[u] != 2'b00) stray++;
    end
    chk("stray_pulses", stray, 0);
    chk("rsp_valid", rsp_valid[u], oh);
    chk("rsp_data", rsp_data[u], exp_reg[u]);
    exp_reg[u] = d;
  endtask

  initial begin
    int         w;
    int         stray;
    int         shr;
    logic [1:0] pat;
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 2'b00;
      req_data0[u] = 8'h00;
      req_data1[u] = 8'h00;
      clear[u]     = 1'b0;
    end
    repeat (3) step();
    chk_reset_vals(0);
    chk_reset_vals(1);
    reset = 1'b0;
    model_reset();
    step();
    chk("sh_reset_post", sh_reset[0], 1);
    step();
    chk("sh_reset_end", sh_reset[0], 0);

    // Single requests, response is the previous register contents.
    req_data0[0] = 8'hA5; req_valid[0] = 2'b01;
    run_txn(0, 1'b0, w);
    chk("t1_rsp_9f", rsp_data[0], 8'h9F);
    req_data1[0] = 8'h3C; req_valid[0] = 2'b10;
    run_txn(0, 1'b0, w);
    chk("t2_rsp_a5", rsp_data[0], 8'hA5);
    req_data0[0] = 8'h00; req_valid[0] = 2'b01;
    run_txn(0, 1'b0, w);
    chk("t2_rsp_3c", rsp_data[0], 8'h3C);

    // clear wins over a simultaneous request.
    step();
    clear[0] = 1'b1; req_data0[0] = 8'h5A; req_valid[0] = 2'b01;
    step();
    chk("clr_sh_reset", sh_reset[0], 1);
    chk("clr_no_ready", req_ready[0], 0);
    chk("clr_busy", busy[0], 1);
    clear[0] = 1'b0;
    step();
    chk("clr_sh_reset_end", sh_reset[0], 0);
    chk("clr_no_ready2", req_ready[0], 0);
    exp_reg[0] = 8'h9F;
    run_txn(0, 1'b0, w);
    chk("clr_grant_wait", w, 1);
    chk("clr_rsp_9f", rsp_data[0], 8'h9F);

    // Both requesters held from reset: alternate grants, back to back.
    reset = 1'b1;
    req_data0[0] = 8'($urandom); req_data1[0] = 8'($urandom); req_valid[0] = 2'b11;
    repeat (2) step();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 1'b1, w);
      chk("rr_grant", req_valid[0] & 2'b11, 2'b11);
      chk("rr_gap", w, 1);
      chk("rr_order", exp_last[0], i % 2);
    end
    req_valid[0] = 2'b00;
    repeat (3) step();
    chk("rr_idle_busy", busy[0], 0);

    // Reset after the third enable aborts the transaction.
    req_data0[0] = 8'($urandom); req_valid[0] = 2'b01;
    w = 0;
    do begin
      step();
      w++;
    end while (req_ready[0] == 2'b00 && w < 20);
    chk("abort_accept", req_ready[0], 2'b01);
    req_valid[0] = 2'b00;
    repeat (3 * 4 + 1) step();
    reset = 1'b1;
    step();
    chk_reset_vals(0);
    step();
    reset = 1'b0;
    model_reset();
    stray = 0;
    shr   = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (rsp_valid[0] != 2'b00) stray++;
      if (sh_reset[0]) shr++;
    end
    chk("abort_no_rsp", stray, 0);
    chk("abort_sh_reset_len", shr, 1);
    req_data0[0] = 8'($urandom); req_valid[0] = 2'b01;
    run_txn(0, 1'b0, w);
    chk("abort_rsp_9f", rsp_data[0], 8'h9F);

    // DIV=1: 0x81, then a held request accepted 10 cycles after the previous accept.
    req_data0[1] = 8'h81; req_valid[1] = 2'b01;
    run_txn(1, 1'b1, w);
    chk("div1_rsp_9f", rsp_data[1], 8'h9F);
    run_txn(1, 1'b0, w);
    chk("div1_b2b_gap", w, 1);
    chk("div1_rsp_81", rsp_data[1], 8'h81);

    // Random request patterns on the DIV=1 unit.
    for (int i = 0; i < 10; i++) begin
      pat = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        if (pat[r] && !req_valid[1][r]) begin
          req_valid[1][r] = 1'b1;
          if (r == 0) req_data0[1] = 8'($urandom);
          else req_data1[1] = 8'($urandom);
        end
      end
      run_txn(1, 1'b0, w);
    end
    req_valid[1] = 2'b00;
    repeat (3) step();
    chk("final_idle", busy[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
